// File: rtl/gfx_fill_rd_arbiter.sv
// gfx_fill_rd_arbiter: shares one MDW-wide frame-buffer read port between NREQ
// graphics read requesters (flood fill, blitter source, colour-key fetch).
// Round-robin grant, bus timeout with error return, optional one-line cache.
//
// Build option: define GFX_FILL_RD_CACHE_EN to enable the single-line read
// cache (32-bit tag, MDW line, valid bit). Without it every grant runs a bus
// cycle and inv_i is ignored.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i[NREQ]           level read request per requester, held until own ack
//   adr_i[32*NREQ]        byte address, requester n at [32n+31:32n]
//   ack_o[NREQ]           one-cycle one-hot read-done pulse
//   err_o                 with ack_o: 1 = bus timeout
//   dat_o[MDW]            read line, valid while ack_o is non-zero
//   inv_i                 pixel write seen; invalidate cached line
//   mem_cyc_o/mem_stb_o   memory bus cycle / strobe (identical)
//   mem_adr_o[32]         line-aligned memory address
//   mem_sel_o[MDW/8]      byte selects, all ones
//   mem_ack_i, mem_dat_i  memory acknowledge and read data
module gfx_fill_rd_arbiter #(
    parameter int unsigned MDW  = 256,
    parameter int unsigned NREQ = 3,
    parameter int unsigned TMO  = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   adr_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 err_o,
    output logic [MDW-1:0]       dat_o,
    input  logic                 inv_i,
    output logic                 mem_cyc_o,
    output logic                 mem_stb_o,
    output logic [31:0]          mem_adr_o,
    output logic [MDW/8-1:0]     mem_sel_o,
    input  logic                 mem_ack_i,
    input  logic [MDW-1:0]       mem_dat_i
);

    localparam int unsigned SELW = MDW / 8;
    localparam int unsigned PW   = $clog2(NREQ);
    localparam int unsigned TW   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   lg_q, lg_d;
    logic [PW-1:0]   g_q, g_d;
    logic [31:0]     la_q, la_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NREQ-1:0] ack_d;
    logic            err_d;
    logic [MDW-1:0]  dat_d;
    logic            cyc_d;
    logic [31:0]     madr_d;
    logic            fill;

    logic            found;
    logic [PW-1:0]   pick;
    logic [31:0]     pick_la;
    logic            hit;
    logic [MDW-1:0]  hit_line;

    assign mem_stb_o = mem_cyc_o;
    assign mem_sel_o = '1;

    // Round-robin search starting one past the last grant.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        pick    = '0;
        pick_la = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(lg_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && (j == idx) && req_i[j]) begin
                    found   = 1'b1;
                    pick    = PW'(j);
                    pick_la = adr_i[32*j +: 32] & ~32'(SELW - 1);
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        g_d     = g_q;
        la_d    = la_q;
        tmo_d   = tmo_q;
        ack_d   = ack_o;
        err_d   = err_o;
        dat_d   = dat_o;
        cyc_d   = mem_cyc_o;
        madr_d  = mem_adr_o;
        fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    lg_d = pick;
                    g_d  = pick;
                    la_d = pick_la;
                    if (hit) begin
                        dat_d   = hit_line;
                        ack_d   = NREQ'(1) << pick;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        madr_d  = pick_la;
                        cyc_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (mem_ack_i) begin
                    cyc_d   = 1'b0;
                    dat_d   = mem_dat_i;
                    ack_d   = NREQ'(1) << g_q;
                    err_d   = 1'b0;
                    fill    = 1'b1;
                    state_d = RESP;
                end else if (tmo_q == TW'(TMO)) begin
                    cyc_d   = 1'b0;
                    dat_d   = '0;
                    ack_d   = NREQ'(1) << g_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                ack_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lg_q      <= PW'(NREQ - 1);
            g_q       <= '0;
            la_q      <= '0;
            tmo_q     <= '0;
            ack_o     <= '0;
            err_o     <= 1'b0;
            dat_o     <= '0;
            mem_cyc_o <= 1'b0;
            mem_adr_o <= '0;
        end else begin
            state_q   <= state_d;
            lg_q      <= lg_d;
            g_q       <= g_d;
            la_q      <= la_d;
            tmo_q     <= tmo_d;
            ack_o     <= ack_d;
            err_o     <= err_d;
            dat_o     <= dat_d;
            mem_cyc_o <= cyc_d;
            mem_adr_o <= madr_d;
        end
    end

`ifdef GFX_FILL_RD_CACHE_EN
    logic            cv_q;
    logic [31:0]     ctag_q;
    logic [MDW-1:0]  cline_q;

    assign hit      = cv_q && (ctag_q == pick_la);
    assign hit_line = cline_q;

    // Line cache; an invalidate beats a coincident fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cv_q    <= 1'b0;
            ctag_q  <= '0;
            cline_q <= '0;
        end else begin
            if (fill) begin
                ctag_q  <= la_q;
                cline_q <= mem_dat_i;
            end
            if (inv_i) begin
                cv_q <= 1'b0;
            end else if (fill) begin
                cv_q <= 1'b1;
            end
        end
    end
`else
    logic unused_nocache;

    assign hit            = 1'b0;
    assign hit_line       = '0;
    assign unused_nocache = ^{inv_i, fill, la_q};
`endif

endmodule

// File: tb/tb_gfx_fill_rd_arbiter.sv
// Self-checking bench for gfx_fill_rd_arbiter: transaction-level model plus
// directed reads with hand-computed latency/data/grant-order expectations.
module tb_gfx_fill_rd_arbiter;

    localparam int unsigned MDW    = 256;
    localparam int unsigned NREQ   = 3;
    localparam int unsigned TMO    = 1023;
    localparam int unsigned PW     = $clog2(NREQ);
    localparam int unsigned LINE_B = MDW / 8;
`ifdef GFX_FILL_RD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_i;
    logic [32*NREQ-1:0]   adr_i;
    logic [NREQ-1:0]      ack_o;
    logic                 err_o;
    logic [MDW-1:0]       dat_o;
    logic                 inv_i;
    logic                 mem_cyc_o;
    logic                 mem_stb_o;
    logic [31:0]          mem_adr_o;
    logic [MDW/8-1:0]     mem_sel_o;
    logic                 mem_ack_i;
    logic [MDW-1:0]       mem_dat_i;

    gfx_fill_rd_arbiter #(.MDW(MDW), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .adr_i     (adr_i),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .dat_o     (dat_o),
        .inv_i     (inv_i),
        .mem_cyc_o (mem_cyc_o),
        .mem_stb_o (mem_stb_o),
        .mem_adr_o (mem_adr_o),
        .mem_sel_o (mem_sel_o),
        .mem_ack_i (mem_ack_i),
        .mem_dat_i (mem_dat_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [MDW-1:0] pat(input logic [31:0] a);
        return {(MDW/32){a ^ 32'hA5A5_0000}};
    endfunction

    // Memory: acknowledges on the (wait_states+1)-th cycle of each bus cycle.
    int unsigned wait_states = 0;
    int unsigned wcnt = 0;
    always @(posedge clk_i) begin
        if (mem_cyc_o === 1'b1 && mem_ack_i !== 1'b1) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign mem_ack_i = (mem_cyc_o === 1'b1) && (wcnt == wait_states);
    assign mem_dat_i = pat(mem_adr_o);

    // Transaction model: cycle n is the interval after clock edge n.
    int             ecnt = 0;
    bit             chk_en = 1'b0;
    bit             m_busy = 1'b0;
    bit             m_hit, m_err;
    int             m_who, m_ack_at, m_last;
    logic [31:0]    m_la;
    logic [MDW-1:0] m_dat;
    bit             c_valid = 1'b0;
    logic [31:0]    c_tag;
    logic [MDW-1:0] c_line;

    always @(posedge clk_i) begin : model
        bit          was_busy;
        int          idx;
        logic [31:0] a;
        ecnt = ecnt + 1;
        if (rst_i) begin
            chk_en  = 1'b1;
            m_busy  = 1'b0;
            m_last  = int'(NREQ) - 1;
            c_valid = 1'b0;
        end else begin
            was_busy = m_busy;
            if (!was_busy) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (m_last + k) % int'(NREQ);
                    if (!m_busy && req_i[PW'(idx)]) begin
                        a      = adr_i[32*idx +: 32];
                        m_la   = (a / LINE_B) * LINE_B;
                        m_busy = 1'b1;
                        m_who  = idx;
                        m_last = idx;
                        if (CACHE_EN && c_valid && c_tag == m_la) begin
                            m_hit = 1'b1; m_err = 1'b0; m_ack_at = ecnt; m_dat = c_line;
                        end else if (wait_states <= TMO) begin
                            m_hit = 1'b0; m_err = 1'b0;
                            m_ack_at = ecnt + int'(wait_states) + 1; m_dat = pat(m_la);
                        end else begin
                            m_hit = 1'b0; m_err = 1'b1;
                            m_ack_at = ecnt + int'(TMO) + 1; m_dat = '0;
                        end
                    end
                end
            end
            if (was_busy && !m_hit && !m_err && ecnt == m_ack_at) begin
                c_tag = m_la; c_line = m_dat; c_valid = 1'b1;
            end
            if (inv_i) c_valid = 1'b0;
            if (was_busy && ecnt == m_ack_at + 1) m_busy = 1'b0;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc_total = 0;
    int ack0_total = 0;
    logic [31:0] last_cyc_adr = '0;

    task automatic check(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        logic [NREQ-1:0] e_ack;
        bit              e_cyc;
        @(negedge clk_i);
        if (chk_en) begin
            e_ack = (m_busy && ecnt == m_ack_at) ? (NREQ'(1) << m_who) : '0;
            e_cyc = m_busy && !m_hit && (ecnt < m_ack_at);
            check("ack_o", MDW'(ack_o), MDW'(e_ack));
            check("err_o", MDW'(err_o), MDW'((e_ack != '0) && m_err));
            if (e_ack != '0) check("dat_o", dat_o, m_dat);
            check("mem_cyc_o", MDW'(mem_cyc_o), MDW'(e_cyc));
            check("mem_stb_o", MDW'(mem_stb_o), MDW'(e_cyc));
            if (e_cyc) check("mem_adr_o", MDW'(mem_adr_o), MDW'(m_la));
            check("mem_sel_o", MDW'(mem_sel_o), MDW'({(MDW/8){1'b1}}));
        end
        if (mem_cyc_o === 1'b1) begin
            cyc_total++;
            last_cyc_adr = mem_adr_o;
        end
        if (ack_o[0] === 1'b1) ack0_total++;
    endtask

    task automatic do_read(input int n, input logic [31:0] a, input bit inv_on_ack,
                           output int lat, output logic err, output logic [MDW-1:0] dat);
        bit seen;
        seen = 1'b0;
        err  = 1'bx;
        dat  = 'x;
        lat  = 0;
        tick();
        adr_i[32*n +: 32] = a;
        req_i = req_i | (NREQ'(1) << n);
        for (int c = 1; c <= 2000 && !seen; c++) begin
            tick();
            if (inv_on_ack) inv_i = 1'b0;
            if (inv_on_ack && mem_ack_i) inv_i = 1'b1;
            if (ack_o[PW'(n)] === 1'b1) begin
                lat  = c;
                err  = err_o;
                dat  = dat_o;
                req_i = req_i & ~(NREQ'(1) << n);
                seen = 1'b1;
            end
        end
        check("read_done", MDW'(seen), MDW'(1'b1));
        if (!seen) req_i = req_i & ~(NREQ'(1) << n);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    int             lat, c0, ng, a0;
    logic           err;
    logic [MDW-1:0] dat;
    logic [31:0]    dlo;
    int             order[6];
    int             got[NREQ];
    int             exp_order[6] = '{0, 1, 2, 0, 1, 2};
    logic [NREQ-1:0] pend;
    bit             acked;

    initial begin
        rst_i = 1'b1;
        req_i = '0;
        adr_i = '0;
        inv_i = 1'b0;
        repeat (3) tick();
        check("rst_ack", MDW'(ack_o), '0);
        check("rst_err", MDW'(err_o), '0);
        check("rst_dat", dat_o, '0);
        check("rst_cyc", MDW'(mem_cyc_o), '0);
        check("rst_adr", MDW'(mem_adr_o), '0);
        rst_i = 1'b0;

        // Single zero-wait miss.
        wait_states = 0;
        c0 = cyc_total;
        do_read(0, 32'h0000_1044, 1'b0, lat, err, dat);
        dlo = dat[31:0];
        check("t1_lat", MDW'(lat), MDW'(2));
        check("t1_err", MDW'(err), '0);
        check("t1_dat", MDW'(dlo), MDW'(32'hA5A5_1040));
        check("t1_cyc_len", MDW'(cyc_total - c0), MDW'(1));
        check("t1_adr", MDW'(last_cyc_adr), MDW'(32'h0000_1040));

        // Round robin with all three requesting.
        do_reset();
        wait_states = 2;
        adr_i = {32'h0000_4040, 32'h0000_3020, 32'h0000_2000};
        for (int j = 0; j < int'(NREQ); j++) got[j] = 0;
        ng = 0;
        pend = '0;
        c0 = cyc_total;
        tick();
        req_i = '1;
        for (int c = 0; c < 300 && ng < 6; c++) begin
            tick();
            req_i = req_i | pend;
            pend  = '0;
            for (int j = 0; j < int'(NREQ); j++) begin
                if (ack_o[PW'(j)] === 1'b1) begin
                    if (ng < 6) order[ng] = j;
                    ng++;
                    got[j]++;
                    req_i = req_i & ~(NREQ'(1) << j);
                    if (got[j] < 2) pend = pend | (NREQ'(1) << j);
                end
            end
        end
        check("t2_grants", MDW'(ng), MDW'(6));
        for (int i = 0; i < 6; i++) check("t2_order", MDW'(order[i]), MDW'(exp_order[i]));
        check("t2_cyc_total", MDW'(cyc_total - c0), MDW'(18));
        req_i = '0;

        // Same-line reread: cache hit when the cache is built in.
        wait_states = 0;
        do_read(0, 32'h0000_1040, 1'b0, lat, err, dat);
        check("t3_first_lat", MDW'(lat), MDW'(2));
        c0 = cyc_total;
        do_read(0, 32'h0000_105C, 1'b0, lat, err, dat);
        dlo = dat[31:0];
        check("t3_lat", MDW'(lat), CACHE_EN ? MDW'(1) : MDW'(2));
        check("t3_cyc", MDW'(cyc_total - c0), CACHE_EN ? MDW'(0) : MDW'(1));
        check("t3_dat", MDW'(dlo), MDW'(32'hA5A5_1040));

        // Invalidate pulse forces a miss.
        tick();
        inv_i = 1'b1;
        tick();
        inv_i = 1'b0;
        c0 = cyc_total;
        do_read(0, 32'h0000_1040, 1'b0, lat, err, dat);
        check("t4_lat", MDW'(lat), MDW'(2));
        check("t4_cyc", MDW'(cyc_total - c0), MDW'(1));
        // Invalidate coincident with the fill: line returned but not kept.
        wait_states = 3;
        do_read(0, 32'h0000_1040, 1'b1, lat, err, dat);
        inv_i = 1'b0;
        dlo = dat[31:0];
        check("t4b_lat", MDW'(lat), MDW'(5));
        check("t4b_dat", MDW'(dlo), MDW'(32'hA5A5_1040));
        wait_states = 0;
        do_read(0, 32'h0000_1040, 1'b0, lat, err, dat);
        check("t4c_lat", MDW'(lat), MDW'(2));

        // Bus timeout.
        wait_states = 100000;
        c0 = cyc_total;
        do_read(1, 32'h0000_5000, 1'b0, lat, err, dat);
        check("t5_lat", MDW'(lat), MDW'(1025));
        check("t5_err", MDW'(err), MDW'(1'b1));
        check("t5_dat", dat, '0);
        check("t5_cyc", MDW'(cyc_total - c0), MDW'(1024));
        wait_states = 0;
        do_read(1, 32'h0000_5000, 1'b0, lat, err, dat);
        dlo = dat[31:0];
        check("t5b_lat", MDW'(lat), MDW'(2));
        check("t5b_err", MDW'(err), '0);
        check("t5b_dat", MDW'(dlo), MDW'(32'hA5A5_5000));

        // Reset in the middle of a bus cycle.
        do_reset();
        wait_states = 5;
        adr_i = {32'h0000_8000, 32'h0000_7000, 32'h0000_6000};
        tick();
        req_i = 3'b011;
        a0 = ack0_total;
        repeat (3) tick();
        check("t6_in_bus", MDW'(mem_cyc_o), MDW'(1'b1));
        rst_i = 1'b1;
        tick();
        check("t6_cyc", MDW'(mem_cyc_o), '0);
        check("t6_stb", MDW'(mem_stb_o), '0);
        check("t6_ack", MDW'(ack_o), '0);
        rst_i = 1'b0;
        req_i = 3'b010;
        acked = 1'b0;
        for (int c = 0; c < 50 && !acked; c++) begin
            tick();
            if (ack_o !== '0) begin
                acked = 1'b1;
                check("t6_grant", MDW'(ack_o), MDW'(3'b010));
                req_i = '0;
            end
        end
        check("t6_acked", MDW'(acked), MDW'(1'b1));
        check("t6_no_ack0", MDW'(ack0_total - a0), '0);
        req_i = '0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
